clk_rst_sequencer: RTL

CLK_RST_SEQUENCER -- requirements
Module: clk_rst_sequencer

---
 rtl/clk_rst_sequencer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/clk_rst_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : clk_rst_sequencer
// Brief    : PLL reset / lock qualification / downstream reset release FSM.
// Revision : 1.0 - initial release
// ============================================================================
module clk_rst_sequencer #(
    parameter int PLL_RST_CYCLES     = 16,
    parameter int LOCK_TIMEOUT       = 4096,
    parameter int LOCK_STABLE_CYCLES = 64,
    parameter int RST_RELEASE_CYCLES = 8
) (
    input  logic       clk_in1,
    input  logic       reset,
    input  logic       locked,
    input  logic       force_relock,
    input  logic       clr_status,
    output logic       pll_rst,
    output logic       rst_out,
    output logic       ready,
    output logic [2:0] state,
    output logic       lock_lost,
    output logic [7:0] retry_count
);

    localparam logic [2:0] c_st_pll_rst   = 3'd0;
    localparam logic [2:0] c_st_wait_lock = 3'd1;
    localparam logic [2:0] c_st_stable    = 3'd2;
    localparam logic [2:0] c_st_release   = 3'd3;
    localparam logic [2:0] c_st_run       = 3'd4;

    localparam int c_max_ab  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int c_max_cd  = (LOCK_STABLE_CYCLES > RST_RELEASE_CYCLES) ? LOCK_STABLE_CYCLES : RST_RELEASE_CYCLES;
    localparam int c_cnt_max = (c_max_ab > c_max_cd) ? c_max_ab : c_max_cd;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

    localparam logic [c_cnt_w-1:0] c_pll_last     = c_cnt_w'(PLL_RST_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_timeout_last = c_cnt_w'(LOCK_TIMEOUT - 1);
    localparam logic [c_cnt_w-1:0] c_stable_last  = c_cnt_w'(LOCK_STABLE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_release_last = c_cnt_w'(RST_RELEASE_CYCLES - 1);

    logic               r_lock_meta;
    logic               r_lock_sync;
    logic [2:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_pll_rst;
    logic               r_rst_out;
    logic               r_ready;
    logic               r_lock_lost;
    logic [7:0]         r_retry_count;

    logic [2:0]         w_state_nxt;
    logic               w_retry_inc;
    logic               w_lost_set;

    always_comb begin
        w_state_nxt = r_state;
        w_retry_inc = 1'b0;
        w_lost_set  = 1'b0;
        case (r_state)
            c_st_pll_rst: begin
                if (r_cnt == c_pll_last) w_state_nxt = c_st_wait_lock;
            end
            c_st_wait_lock: begin
                // Lock seen on the final timeout cycle still counts as success.
                if (r_lock_sync) begin
                    w_state_nxt = c_st_stable;
                end else if (r_cnt == c_timeout_last) begin
                    w_state_nxt = c_st_pll_rst;
                    w_retry_inc = 1'b1;
                end
            end
            c_st_stable: begin
                if (!r_lock_sync)                 w_state_nxt = c_st_wait_lock;
                else if (r_cnt == c_stable_last)  w_state_nxt = c_st_release;
            end
            c_st_release: begin
                if (!r_lock_sync)                 w_state_nxt = c_st_wait_lock;
                else if (r_cnt == c_release_last) w_state_nxt = c_st_run;
            end
            c_st_run: begin
                // Lock loss outranks a concurrent relock request.
                if (!r_lock_sync) begin
                    w_state_nxt = c_st_pll_rst;
                    w_retry_inc = 1'b1;
                    w_lost_set  = 1'b1;
                end else if (force_relock) begin
                    w_state_nxt = c_st_pll_rst;
                end
            end
            default: w_state_nxt = c_st_pll_rst;
        endcase
    end

    always_ff @(posedge clk_in1 or posedge reset) begin
        if (reset) begin
            r_lock_meta   <= 1'b0;
            r_lock_sync   <= 1'b0;
            r_state       <= c_st_pll_rst;
            r_cnt         <= '0;
            r_pll_rst     <= 1'b1;
            r_rst_out     <= 1'b1;
            r_ready       <= 1'b0;
            r_lock_lost   <= 1'b0;
            r_retry_count <= 8'd0;
        end else begin
            r_lock_meta <= locked;
            r_lock_sync <= r_lock_meta;
            r_state     <= w_state_nxt;

            if (w_state_nxt != r_state)  r_cnt <= '0;
            else if (r_state != c_st_run) r_cnt <= r_cnt + 1'b1;

            // Outputs decoded from the next state so they move with the state register.
            r_pll_rst <= (w_state_nxt == c_st_pll_rst);
            r_rst_out <= (w_state_nxt != c_st_run);
            r_ready   <= (w_state_nxt == c_st_run);

            if (w_lost_set)      r_lock_lost <= 1'b1;
            else if (clr_status) r_lock_lost <= 1'b0;

            if (w_retry_inc) begin
                if (clr_status)                  r_retry_count <= 8'd1;
                else if (r_retry_count != 8'hFF) r_retry_count <= r_retry_count + 8'd1;
            end else if (clr_status) begin
                r_retry_count <= 8'd0;
            end
        end
    end

    assign pll_rst     = r_pll_rst;
    assign rst_out     = r_rst_out;
    assign ready       = r_ready;
    assign state       = r_state;
    assign lock_lost   = r_lock_lost;
    assign retry_count = r_retry_count;

endmodule
`default_nettype wire
